wave_sequencer: RTL and testbench

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

---
 rtl/wave_sequencer.sv | 157 +++++++++++++++
 tb/tb_wave_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// wave_sequencer
//   Steps through an 8-entry program of function_generator settings. Each
//   entry holds its settings for max(dwell,1) clk cycles. init pulses low for
//   one cycle whenever an entry is applied.
//
//   Optional feature: define SEQ_LOOP_EN to wrap from last_idx back to entry 0
//   until stop. Without it, the block pulses done once and returns to IDLE.
//
// Ports
//   clk, rst                 clock and asynchronous active-low reset
//   wr_en, wr_addr,          program write port; may be used while busy
//   wr_cfg, wr_dwell         wr_cfg = {Sel, AmpSel, Phase_cntrl, PI}
//   last_idx                 final entry; sampled at each advance
//   start, stop              start from entry 0 / abort (stop wins)
//   Sel, AmpSel,             registered settings for function_generator
//   Phase_cntrl, PI
//   init                     active-low, 1-cycle pulse per applied entry
//   busy, step_idx, done     sequence active, current entry, end pulse
module wave_sequencer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [9:0]         wr_cfg,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [2:0]         last_idx,
  input  logic               start,
  input  logic               stop,
  output logic [2:0]         Sel,
  output logic [1:0]         AmpSel,
  output logic [1:0]         Phase_cntrl,
  output logic [2:0]         PI,
  output logic               init,
  output logic               busy,
  output logic [2:0]         step_idx,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, APPLY, DWELL, FINISH} state_t;

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  state_t             state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] load_cnt;
  logic               adv;
  logic               apply_go;

  logic [9:0]         cfg_mem   [8];
  logic [DWELL_W-1:0] dwell_mem [8];

  // A dwell of 0 behaves like 1, so the counter load is max(dwell,1)-1.
  assign load_cnt = (dwell_mem[idx] == '0) ? '0 : dwell_mem[idx] - ONE;

  // Outputs update only on an APPLY cycle that is not being aborted.
  assign apply_go = (state == APPLY) && !stop;

  // Program storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        cfg_mem[i]   <= '0;
        dwell_mem[i] <= ONE;
      end
    end else if (wr_en) begin
      cfg_mem[wr_addr]   <= wr_cfg;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = APPLY;
            idx_nxt   = '0;
          end
        end
        APPLY: begin
          cnt_nxt = load_cnt;
          if (load_cnt != '0) state_nxt = DWELL;
          else                adv       = 1'b1;
        end
        DWELL: begin
          // APPLY already used one cycle of the dwell, so leave as the
          // count reaches 0; cnt never drops below 0 here.
          if (cnt <= ONE) begin
            cnt_nxt = '0;
            adv     = 1'b1;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase

      if (adv) begin
        if (idx != last_idx) begin
          idx_nxt   = idx + 3'd1;
          state_nxt = APPLY;
        end else begin
`ifdef SEQ_LOOP_EN
          idx_nxt   = '0;
          state_nxt = APPLY;
`else
          state_nxt = FINISH;
`endif
        end
      end
    end
  end

  // Registered settings and init: visible one edge after the APPLY cycle,
  // held unchanged in IDLE and FINISH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {Sel, AmpSel, Phase_cntrl, PI} <= '0;
      init                           <= 1'b1;
    end else begin
      init <= !apply_go;
      if (apply_go) {Sel, AmpSel, Phase_cntrl, PI} <= cfg_mem[idx];
    end
  end

  // Status outputs
  always_comb begin
    busy     = (state == APPLY) || (state == DWELL);
    done     = (state == FINISH);
    step_idx = idx;
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer. The expected output trace of a run
// is built from the program contents: each entry expands into max(dwell,1)
// cycles, settings/init lag the sequence by one edge, while busy/step_idx
// follow the sequence directly.
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [9:0]  wr_cfg;
  logic [15:0] wr_dwell;
  logic [2:0]  last_idx;
  logic        start, stop;
  logic [2:0]  Sel;
  logic [1:0]  AmpSel, Phase_cntrl;
  logic [2:0]  PI;
  logic        init, busy, done;
  logic [2:0]  step_idx;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0]  m_cfg [8];
  logic [15:0] m_dw  [8];
  logic [9:0]  held;

  always #5 clk = ~clk;

  wave_sequencer #(.DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cfg(wr_cfg),
    .wr_dwell(wr_dwell), .last_idx(last_idx), .start(start), .stop(stop),
    .Sel(Sel), .AmpSel(AmpSel), .Phase_cntrl(Phase_cntrl), .PI(PI),
    .init(init), .busy(busy), .step_idx(step_idx), .done(done)
  );

  wire [9:0] cfg_out = {Sel, AmpSel, Phase_cntrl, PI};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_cfg[i] = '0;
      m_dw[i]  = 16'd1;
    end
    held = '0;
  endtask

  task automatic wr(input int a, input logic [9:0] c, input logic [15:0] d);
    wr_addr  = 3'(a);
    wr_cfg   = c;
    wr_dwell = d;
    wr_en    = 1'b1;
    tick();
    wr_en    = 1'b0;
    m_cfg[a] = c;
    m_dw[a]  = d;
  endtask

  // Start a sequence over entries 0..last and compare every cycle against
  // the expanded trace.
  task automatic run_check(input string tag, input int last);
    int q[$];
    bit f[$];
    int t;
    for (int i = 0; i <= last; i++) begin
      int n;
      n = (m_dw[i] == 0) ? 1 : int'(m_dw[i]);
      for (int k = 0; k < n; k++) begin
        q.push_back(i);
        f.push_back(k == 0);
      end
    end
    t = q.size();
    last_idx = 3'(last);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy0"}, 32'(busy), 32'd1);
    chk({tag, " step0"}, 32'(step_idx), 32'(q[0]));
    chk({tag, " cfg0"}, 32'(cfg_out), 32'(held));
    chk({tag, " init0"}, 32'(init), 32'd1);
    for (int j = 1; j < t; j++) begin
      tick();
      chk({tag, " cfg"}, 32'(cfg_out), 32'(m_cfg[q[j-1]]));
      chk({tag, " init"}, 32'(init), 32'(!f[j-1]));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " step"}, 32'(step_idx), 32'(q[j]));
      chk({tag, " done"}, 32'(done), 32'd0);
    end
    held = m_cfg[q[t-1]];
    tick();
    chk({tag, " cfg_end"}, 32'(cfg_out), 32'(held));
    chk({tag, " init_end"}, 32'(init), 32'(!f[t-1]));
`ifdef SEQ_LOOP_EN
    chk({tag, " wrap_busy"}, 32'(busy), 32'd1);
    chk({tag, " wrap_step"}, 32'(step_idx), 32'd0);
    chk({tag, " wrap_done"}, 32'(done), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({tag, " stop_busy"}, 32'(busy), 32'd0);
    chk({tag, " stop_done"}, 32'(done), 32'd0);
    chk({tag, " stop_cfg"}, 32'(cfg_out), 32'(held));
    chk({tag, " stop_init"}, 32'(init), 32'd1);
`else
    chk({tag, " fin_busy"}, 32'(busy), 32'd0);
    chk({tag, " fin_done"}, 32'(done), 32'd1);
    tick();
    chk({tag, " idle_done"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " idle_init"}, 32'(init), 32'd1);
    chk({tag, " idle_cfg"}, 32'(cfg_out), 32'(held));
`endif
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_cfg = '0; wr_dwell = '0;
    last_idx = '0; start = 1'b0; stop = 1'b0;
    model_clear();
    tick();
    tick();
    chk("rst cfg", 32'(cfg_out), 32'd0);
    chk("rst init", 32'(init), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst step", 32'(step_idx), 32'd0);
    rst = 1'b1;
    tick();

    // Single entry, dwell 4
    wr(0, 10'b110_00_01_101, 16'd4);
    run_check("single", 0);

    // Dwell 3, 0, 2: zero dwell behaves as one cycle
    wr(0, 10'h2a5, 16'd3);
    wr(1, 10'h15a, 16'd0);
    wr(2, 10'h3c3, 16'd2);
    run_check("three", 2);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss busy", 32'(busy), 32'd0);
    chk("ss init", 32'(init), 32'd1);
    tick();
    chk("ss busy2", 32'(busy), 32'd0);
    chk("ss cfg", 32'(cfg_out), 32'(held));

    // stop in second DWELL cycle of entry 1
    wr(0, 10'h111, 16'd2);
    wr(1, 10'h222, 16'd4);
    last_idx = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stop pre_cfg", 32'(cfg_out), 32'h222);
    chk("stop pre_step", 32'(step_idx), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop busy", 32'(busy), 32'd0);
    chk("stop done", 32'(done), 32'd0);
    chk("stop cfg", 32'(cfg_out), 32'h222);
    chk("stop init", 32'(init), 32'd1);
    tick();
    chk("stop done2", 32'(done), 32'd0);
    held = 10'h222;

`ifdef SEQ_LOOP_EN
    // Looping order 0,1,0 with a rewrite of entry 0 during entry 1
    wr(0, 10'h0aa, 16'd2);
    wr(1, 10'h0bb, 16'd3);
    last_idx = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("loop cfgA", 32'(cfg_out), 32'h0aa);
    tick();
    chk("loop step1", 32'(step_idx), 32'd1);
    tick();
    chk("loop cfgB", 32'(cfg_out), 32'h0bb);
    chk("loop initB", 32'(init), 32'd0);
    wr_addr = 3'd0; wr_cfg = 10'h0cc; wr_dwell = 16'd2; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    m_cfg[0] = 10'h0cc; m_dw[0] = 16'd2;
    chk("loop cfgB2", 32'(cfg_out), 32'h0bb);
    tick();
    chk("loop wrap_step", 32'(step_idx), 32'd0);
    chk("loop wrap_done", 32'(done), 32'd0);
    tick();
    chk("loop cfgC", 32'(cfg_out), 32'h0cc);
    chk("loop initC", 32'(init), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop stop_busy", 32'(busy), 32'd0);
    held = 10'h0cc;
`endif

    // Reset in the middle of a dwell
    wr(0, 10'h3ff, 16'd6);
    last_idx = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst cfg", 32'(cfg_out), 32'd0);
    chk("mid_rst init", 32'(init), 32'd1);
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst done", 32'(done), 32'd0);
    chk("mid_rst step", 32'(step_idx), 32'd0);
    tick();
    rst = 1'b1;
    model_clear();
    tick();
    run_check("cleared", 7);

    // Randomized programs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++)
        wr(i, 10'($urandom_range(0, 1023)), 16'($urandom_range(0, 5)));
      run_check("rand", int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
